mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 183 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM stage of the pipeline: issues data-memory requests for loads/stores,
// stalls the front of the pipeline while memory is busy, aligns load data,
// and owns the MEM/WB pipeline register.
//
// Build option: define MISALIGN_TRAP_EN to trap misaligned word accesses
// (no request, one-cycle misalign pulse, write-back suppressed). Without it,
// misalign is tied low and the access uses the word-aligned address.
//
// Ports
//   clk, regResetN           clock, asynchronous active-low reset
//   mem2Reg_mem .. link_mem  EX/MEM control bits
//   aluResult_mem            byte address (memory op) or ALU result
//   busB_mem                 store data
//   rw_mem                   destination register
//   instru_memAddress        PC of the instruction in MEM
//   dmReq/dmWe/dmAddr/dmWdata/dmByteEn   data-memory request side
//   dmReady/dmRdata          data-memory response side
//   stall_mem                freezes PC, IF/ID, ID/EX, EX/MEM
//   regWr_wb/rw_wb/busW_wb   MEM/WB register
//   memErr                   one-cycle pulse when an access times out
//   misalign                 one-cycle pulse on a trapped misaligned access
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        regResetN,
  input  logic        mem2Reg_mem,
  input  logic        regWr_mem,
  input  logic        memWr_mem,
  input  logic        lb_mem,
  input  logic        lbu_mem,
  input  logic        sb_mem,
  input  logic        link_mem,
  input  logic [31:0] aluResult_mem,
  input  logic [31:0] busB_mem,
  input  logic [4:0]  rw_mem,
  input  logic [31:0] instru_memAddress,
  output logic        dmReq,
  output logic        dmWe,
  output logic [31:0] dmAddr,
  output logic [31:0] dmWdata,
  output logic [3:0]  dmByteEn,
  input  logic        dmReady,
  input  logic [31:0] dmRdata,
  output logic        stall_mem,
  output logic        regWr_wb,
  output logic [4:0]  rw_wb,
  output logic [31:0] busW_wb,
  output logic        memErr,
  output logic        misalign
);

  typedef enum logic {IDLE, WAIT} state_e;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        regwr_q;
  logic [4:0]  rw_q;
  logic [31:0] busw_q;

  logic        mem_op;
  logic        mis_hit;
  logic        req;
  logic        tmo_hit;
  logic        mis_pulse;
  logic [1:0]  lane;
  logic [7:0]  ld_byte;
  logic [31:0] ld_res;
  logic [31:0] wb_data;

  assign mem_op = mem2Reg_mem | memWr_mem;
  assign lane   = aluResult_mem[1:0];

`ifdef MISALIGN_TRAP_EN
  assign mis_hit = mem_op & ~(lb_mem | lbu_mem | sb_mem) & (lane != 2'b00);
`else
  assign mis_hit = 1'b0;
`endif

  // The cycle with cnt_q == TMO is the last chance: dmReady still completes
  // the access there, otherwise the request is withdrawn so the stall lifts
  // and the abandoned instruction leaves MEM as a bubble.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req       = 1'b0;
    tmo_hit   = 1'b0;
    mis_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op) begin
          if (mis_hit) begin
            mis_pulse = 1'b1;
          end else begin
            req = 1'b1;
            if (!dmReady) begin
              state_d = WAIT;
              cnt_d   = '0;
            end
          end
        end
      end
      WAIT: begin
        if ((cnt_q == TMO) && !dmReady) begin
          tmo_hit = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          req = 1'b1;
          if (dmReady) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    ld_byte = dmRdata[7:0];
    case (lane)
      2'd0: ld_byte = dmRdata[7:0];
      2'd1: ld_byte = dmRdata[15:8];
      2'd2: ld_byte = dmRdata[23:16];
      2'd3: ld_byte = dmRdata[31:24];
      default: ld_byte = dmRdata[7:0];
    endcase
    if (lb_mem)       ld_res = {{24{ld_byte[7]}}, ld_byte};
    else if (lbu_mem) ld_res = {24'd0, ld_byte};
    else              ld_res = dmRdata;
    if (link_mem)         wb_data = instru_memAddress + 32'd4;
    else if (mem2Reg_mem) wb_data = ld_res;
    else                  wb_data = aluResult_mem;
  end

  always_ff @(posedge clk or negedge regResetN) begin
    if (!regResetN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge regResetN) begin
    if (!regResetN) begin
      regwr_q <= 1'b0;
      rw_q    <= '0;
      busw_q  <= '0;
    end else if (stall_mem || tmo_hit || mis_pulse) begin
      regwr_q <= 1'b0;
    end else begin
      regwr_q <= regWr_mem;
      rw_q    <= rw_mem;
      busw_q  <= wb_data;
    end
  end

  assign dmReq     = req;
  assign dmWe      = memWr_mem;
  assign dmAddr    = {aluResult_mem[31:2], 2'b00};
  assign dmByteEn  = sb_mem ? (4'b0001 << lane) : 4'hF;
  assign dmWdata   = sb_mem ? {4{busB_mem[7:0]}} : busB_mem;
  assign stall_mem = req & ~dmReady;
  assign memErr    = tmo_hit;
  assign misalign  = mis_pulse;
  assign regWr_wb  = regwr_q;
  assign rw_wb     = rw_q;
  assign busW_wb   = busw_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: the driver issues one instruction at
// a time, holds it for the number of cycles the access should take, and
// pushes the expected retirement; the monitor checks every cycle and pops an
// entry whenever the stage retires an instruction (stall_mem low at an edge).
module tb_mem_access_unit;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        regResetN = 1'b0;
  logic        mem2Reg_mem = 0, regWr_mem = 0, memWr_mem = 0;
  logic        lb_mem = 0, lbu_mem = 0, sb_mem = 0, link_mem = 0;
  logic [31:0] aluResult_mem = '0, busB_mem = '0, instru_memAddress = '0;
  logic [4:0]  rw_mem = '0;
  logic        dmReq, dmWe, dmReady = 1'b0;
  logic [31:0] dmAddr, dmWdata, dmRdata = '0;
  logic [3:0]  dmByteEn;
  logic        stall_mem, regWr_wb, memErr, misalign;
  logic [4:0]  rw_wb;
  logic [31:0] busW_wb;

  mem_access_unit #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .regResetN(regResetN),
    .mem2Reg_mem(mem2Reg_mem), .regWr_mem(regWr_mem), .memWr_mem(memWr_mem),
    .lb_mem(lb_mem), .lbu_mem(lbu_mem), .sb_mem(sb_mem), .link_mem(link_mem),
    .aluResult_mem(aluResult_mem), .busB_mem(busB_mem), .rw_mem(rw_mem),
    .instru_memAddress(instru_memAddress),
    .dmReq(dmReq), .dmWe(dmWe), .dmAddr(dmAddr), .dmWdata(dmWdata),
    .dmByteEn(dmByteEn), .dmReady(dmReady), .dmRdata(dmRdata),
    .stall_mem(stall_mem), .regWr_wb(regWr_wb), .rw_wb(rw_wb),
    .busW_wb(busW_wb), .memErr(memErr), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          stalls;
    logic        req, memerr, mis, memop, store;
    logic [31:0] daddr, wdata;
    logic        dwe;
    logic [3:0]  ben;
    logic        regwr;
    logic [4:0]  rw;
    logic [31:0] busw;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0, errors = 0;
  logic        mon_en = 1'b0;
  logic [4:0]  h_rw = '0;
  logic [31:0] h_busw = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // kind: 0 alu, 1 link, 2 lw, 3 lb, 4 lbu, 5 sw, 6 sb
  task automatic issue(input int kind, input logic [31:0] addr, input logic [31:0] busb,
                       input logic [31:0] pc, input logic [31:0] rdata,
                       input logic [4:0] rw, input logic regwr, input int lat);
    exp_t e;
    logic mem, load, mis, tmo;
    int   k, last;
    logic [31:0] b8, ld;
    mem  = (kind >= 2);
    load = (kind >= 2) && (kind <= 4);
    k    = int'(addr[1:0]);
`ifdef MISALIGN_TRAP_EN
    mis = (kind == 2 || kind == 5) && (k != 0);
`else
    mis = 1'b0;
`endif
    // A request gets T wait cycles plus one final cycle in which a
    // ready response still wins; after that it is abandoned.
    if (!mem || mis) begin last = 0; tmo = 1'b0; end
    else if (lat <= T + 1) begin last = lat; tmo = 1'b0; end
    else begin last = T + 1; tmo = 1'b1; end

    b8 = (rdata >> (8 * k)) & 32'hFF;
    if (kind == 3)      ld = (b8 >= 32'd128) ? (b8 | 32'hFFFFFF00) : b8;
    else if (kind == 4) ld = b8;
    else                ld = rdata;

    e.stalls = last;
    e.memop  = mem;
    e.req    = mem && !mis && !tmo;
    e.memerr = tmo;
    e.mis    = mis;
    e.store  = (kind >= 5);
    e.daddr  = addr & 32'hFFFF_FFFC;
    e.dwe    = (kind >= 5);
    e.ben    = (kind == 6) ? 4'(1 << k) : 4'hF;
    e.wdata  = (kind == 6) ? (busb & 32'hFF) * 32'h01010101 : busb;
    if (mis || tmo) begin
      e.regwr = 1'b0; e.rw = h_rw; e.busw = h_busw;
    end else begin
      e.regwr = regwr; e.rw = rw;
      e.busw  = (kind == 1) ? pc + 32'd4 : load ? ld : addr;
      h_rw = rw; h_busw = e.busw;
    end
    sb_q.push_back(e);

    mem2Reg_mem = load; memWr_mem = (kind >= 5); regWr_mem = regwr;
    lb_mem = (kind == 3); lbu_mem = (kind == 4); sb_mem = (kind == 6);
    link_mem = (kind == 1); aluResult_mem = addr; busB_mem = busb;
    instru_memAddress = pc; rw_mem = rw;
    for (int c = 0; c <= last; c++) begin
      if (mem && !mis) dmReady = (c == lat);
      else             dmReady = 1'($urandom_range(0, 1));
      dmRdata = (c == lat) ? rdata : $urandom;
      @(posedge clk); #1;
    end
  endtask

  // Monitor
  initial begin
    logic s_stall, s_err, s_mis, s_req, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_ben;
    logic [4:0]  m_rw;
    logic [31:0] m_busw;
    int nst;
    exp_t e;
    nst = 0; m_rw = '0; m_busw = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) continue;
      s_stall = stall_mem; s_err = memErr; s_mis = misalign; s_req = dmReq;
      s_we = dmWe; s_addr = dmAddr; s_wdata = dmWdata; s_ben = dmByteEn;
      @(posedge clk); #1;
      if (s_stall) begin
        nst++;
        chk("bubble_regWr", 32'(regWr_wb), 32'd0);
        chk("bubble_rw_hold", 32'(rw_wb), 32'(m_rw));
        chk("bubble_busW_hold", busW_wb, m_busw);
        chk("stall_memErr", 32'(s_err), 32'd0);
      end else if (sb_q.size() == 0) begin
        chk("unexpected_retire", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("stall_cycles", nst, e.stalls);
        chk("dmReq", 32'(s_req), 32'(e.req));
        chk("memErr", 32'(s_err), 32'(e.memerr));
        chk("misalign", 32'(s_mis), 32'(e.mis));
        if (e.memop) begin
          chk("dmAddr", s_addr, e.daddr);
          chk("dmWe", 32'(s_we), 32'(e.dwe));
          chk("dmByteEn", 32'(s_ben), 32'(e.ben));
          if (e.store) chk("dmWdata", s_wdata, e.wdata);
        end
        chk("regWr_wb", 32'(regWr_wb), 32'(e.regwr));
        chk("rw_wb", 32'(rw_wb), 32'(e.rw));
        chk("busW_wb", busW_wb, e.busw);
        m_rw = e.rw; m_busw = e.busw; nst = 0;
      end
    end
  end

  // Driver
  initial begin
    int kind, r, lat;
    logic [31:0] a;
    #1;
    chk("rst_regWr_wb", 32'(regWr_wb), 32'd0);
    chk("rst_rw_wb", 32'(rw_wb), 32'd0);
    chk("rst_busW_wb", busW_wb, 32'd0);
    chk("rst_memErr", 32'(memErr), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) regResetN = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    issue(2, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 5'd5, 1'b1, 0);
    issue(3, 32'h203, 32'h0, 32'h0, 32'h80112233, 5'd6, 1'b1, 3);
    issue(4, 32'h203, 32'h0, 32'h0, 32'h80112233, 5'd7, 1'b1, 3);
    issue(6, 32'h11, 32'hA5, 32'h0, 32'h0, 5'd0, 1'b0, 1);
    issue(2, 32'h300, 32'h0, 32'h0, 32'h0, 5'd8, 1'b1, 1000);
    issue(1, 32'h77, 32'h0, 32'h400, 32'h0, 5'd31, 1'b1, 0);
    issue(5, 32'h102, 32'h12345678, 32'h0, 32'h0, 5'd0, 1'b0, 0);
    issue(2, 32'h500, 32'h0, 32'h0, 32'hCAFEF00D, 5'd9, 1'b1, T + 1);

    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 6);
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      r = $urandom_range(0, 9);
      lat = (r < 6) ? 0 : (r < 9) ? $urandom_range(1, 4) : 40;
      issue(kind, a, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), lat);
    end
    mon_en = 1'b0;
    #2;
    chk("scoreboard_drained", sb_q.size(), 0);

    // Reset in the middle of a wait: abandon immediately, then the held load
    // restarts from IDLE and completes.
    mem2Reg_mem = 1; memWr_mem = 0; regWr_mem = 1; lb_mem = 0; lbu_mem = 0;
    sb_mem = 0; link_mem = 0; aluResult_mem = 32'h40; rw_mem = 5'd3;
    dmReady = 0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("wait_stall", 32'(stall_mem), 32'd1);
    #2 regResetN = 1'b0;
    #1;
    chk("midrst_regWr_wb", 32'(regWr_wb), 32'd0);
    chk("midrst_rw_wb", 32'(rw_wb), 32'd0);
    chk("midrst_busW_wb", busW_wb, 32'd0);
    chk("midrst_memErr", 32'(memErr), 32'd0);
    chk("midrst_dmReq_idle", 32'(dmReq), 32'd1);
    @(posedge clk); #1;
    regResetN = 1'b1;
    dmReady = 1'b1; dmRdata = 32'h12345678;
    @(negedge clk);
    chk("postrst_stall", 32'(stall_mem), 32'd0);
    @(posedge clk); #1;
    chk("postrst_regWr_wb", 32'(regWr_wb), 32'd1);
    chk("postrst_rw_wb", 32'(rw_wb), 32'd3);
    chk("postrst_busW_wb", busW_wb, 32'h12345678);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
